// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the async FIFO (rclk domain).
// Syncs the write Gray pointer, owns the read pointer and empty flag.
//
// Ports:
//   rclk, rrst_n     read clock, synchronous active-low reset
//   wptr             Gray write pointer from the write domain (async)
//   rptr             registered Gray read pointer to the write domain
//   raddr            memory read address
//   rdata_mem        combinational memory read data at raddr
//   rdata, rvalid,   registered output word with valid/ready handshake
//   rready
//   rempty           registered empty flag
//   rlevel           words in memory not yet fetched
module fifo_rd_ctrl #(
  parameter int DATASIZE = 32,
  parameter int ADDRSIZE = 6
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  input  logic                rready,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rlevel
);

  logic [ADDRSIZE:0]   rq1_wptr_q, rq1_wptr_d;
  logic [ADDRSIZE:0]   rq2_wptr_q, rq2_wptr_d;
  logic [ADDRSIZE:0]   rbin_q, rbin_d;
  logic [ADDRSIZE:0]   rptr_q, rptr_d;
  logic [DATASIZE-1:0] rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                rempty_q, rempty_d;

  logic                fetch;
  logic [ADDRSIZE:0]   rgray_next;
  logic [ADDRSIZE:0]   wbin;

  always_comb begin
    fetch      = !rempty_q && (!rvalid_q || rready);
    rbin_d     = rbin_q + {{ADDRSIZE{1'b0}}, fetch};
    rgray_next = (rbin_d >> 1) ^ rbin_d;
    rptr_d     = rgray_next;
    rq1_wptr_d = wptr;
    rq2_wptr_d = rq1_wptr_q;
    rdata_d    = rdata_q;
    rvalid_d   = rvalid_q;
    if (fetch) begin
      rdata_d  = rdata_mem;
      rvalid_d = 1'b1;
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
    // Full-width compare: a whole-lap difference is not empty.
    rempty_d = (rgray_next == rq2_wptr_q);
  end

  // Gray to binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin[i] = ^(rq2_wptr_q >> i);
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rq1_wptr_q <= '0;
      rq2_wptr_q <= '0;
      rbin_q     <= '0;
      rptr_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rempty_q   <= 1'b1;
    end else begin
      rq1_wptr_q <= rq1_wptr_d;
      rq2_wptr_q <= rq2_wptr_d;
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      rempty_q   <= rempty_d;
    end
  end

  assign rptr   = rptr_q;
  assign raddr  = rbin_q[ADDRSIZE-1:0];
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rempty = rempty_q;
  assign rlevel = wbin - rbin_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: scoreboard bench for fifo_rd_ctrl.
// Directed cases plus a randomized write/backpressure phase.
module tb_fifo_rd_ctrl;

  logic        clk = 1'b0;
  logic        rrst_n;
  logic [6:0]  wptr;
  logic [6:0]  rptr;
  logic [5:0]  raddr;
  logic [31:0] rdata_mem;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic        rempty;
  logic [6:0]  rlevel;

  fifo_rd_ctrl #(.DATASIZE(32), .ADDRSIZE(6)) dut (
    .rclk     (clk),
    .rrst_n   (rrst_n),
    .wptr     (wptr),
    .rptr     (rptr),
    .raddr    (raddr),
    .rdata_mem(rdata_mem),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rready   (rready),
    .rempty   (rempty),
    .rlevel   (rlevel)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] gray(input logic [6:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [31:0] mem [0:63];
  assign rdata_mem = mem[raddr];

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  int          wcnt = 0;
  int          written = 0;
  int          consumed = 0;

  assign wptr = gray(7'(wcnt));

  // Reference: counts of words written/fetched, 2-edge sync delay.
  int   m_f = 0;
  int   m_s1 = 0;
  int   m_s2 = 0;
  logic m_v = 1'b0;
  logic m_e = 1'b1;
  logic m_fe;
  assign m_fe = !m_e && (!m_v || rready);

  always @(posedge clk) begin
    if (!rrst_n) begin
      m_f  <= 0;
      m_s1 <= 0;
      m_s2 <= 0;
      m_v  <= 1'b0;
      m_e  <= 1'b1;
    end else begin
      m_f  <= (m_f + int'(m_fe)) % 128;
      m_v  <= m_fe || (m_v && !rready);
      m_e  <= (((m_f + int'(m_fe)) % 128) == m_s2);
      m_s2 <= m_s1;
      m_s1 <= wcnt;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Monitor: model checks and scoreboard pop on handshake.
  always @(negedge clk) begin
    chk("rvalid_m", 64'(rvalid), 64'(m_v));
    chk("rempty_m", 64'(rempty), 64'(m_e));
    chk("rptr_m", 64'(rptr), 64'(gray(7'(m_f))));
    chk("raddr_m", 64'(raddr), 64'(m_f % 64));
    chk("rlevel_m", 64'(rlevel), 64'((m_s2 - m_f + 128) % 128));
    if (rrst_n && rvalid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_word: got rdata %0h expected no word", rdata);
      end else begin
        chk("sb_rdata", 64'(rdata), 64'(exp_q[0]));
        if (rready) begin
          void'(exp_q.pop_front());
          consumed++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    mem[wcnt % 64] = d;
    exp_q.push_back(d);
    wcnt = (wcnt + 1) % 128;
    written++;
  endtask

  task automatic do_reset(input int n);
    rrst_n = 1'b0;
    rready = 1'b0;
    exp_q.delete();
    wcnt = 0;
    written = 0;
    consumed = 0;
    repeat (n) tick();
    rrst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rrst_n = 1'b0;
    rready = 1'b0;
    wcnt = 6;
    repeat (3) tick();
    chk("rst_rempty", 64'(rempty), 64'd1);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_rptr", 64'(rptr), 64'd0);
    chk("rst_raddr", 64'(raddr), 64'd0);
    chk("rst_rlevel", 64'(rlevel), 64'd0);
    rrst_n = 1'b1;
    wcnt = 0;
    tick();
    chk("rel_rempty", 64'(rempty), 64'd1);
    chk("rel_rvalid", 64'(rvalid), 64'd0);
    chk("rel_rptr", 64'(rptr), 64'd0);
    chk("rel_rlevel", 64'(rlevel), 64'd0);

    // Single word latency.
    rready = 1'b1;
    wr(32'hA5A50001);
    repeat (3) tick();
    chk("sw_e3_rempty", 64'(rempty), 64'd0);
    chk("sw_e3_rvalid", 64'(rvalid), 64'd0);
    tick();
    chk("sw_e4_rvalid", 64'(rvalid), 64'd1);
    chk("sw_e4_rdata", 64'(rdata), 64'hA5A50001);
    chk("sw_e4_raddr", 64'(raddr), 64'd1);
    chk("sw_e4_rptr", 64'(rptr), 64'd1);
    chk("sw_e4_rempty", 64'(rempty), 64'd1);
    tick();
    chk("sw_e5_rvalid", 64'(rvalid), 64'd0);

    // Backpressure.
    do_reset(2);
    wr(32'h10);
    wr(32'h11);
    wr(32'h12);
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_rvalid", 64'(rvalid), 64'd1);
      chk("bp_rdata", 64'(rdata), 64'h10);
      chk("bp_rptr", 64'(rptr), 64'd1);
      chk("bp_rlevel", 64'(rlevel), 64'd2);
      tick();
    end
    rready = 1'b1;
    tick();
    chk("bp_d1", 64'(rdata), 64'h11);
    chk("bp_v1", 64'(rvalid), 64'd1);
    tick();
    chk("bp_d2", 64'(rdata), 64'h12);
    chk("bp_v2", 64'(rvalid), 64'd1);
    tick();
    chk("bp_v3", 64'(rvalid), 64'd0);
    chk("bp_lvl3", 64'(rlevel), 64'd0);

    // Wrap: 130 words, data = index.
    do_reset(2);
    rready = 1'b1;
    begin
      int  cyc;
      bit  seen64;
      cyc = 0;
      seen64 = 0;
      while (consumed < 130 && cyc < 1000) begin
        if (written < 130 && written - consumed < 64)
          wr(32'(written));
        tick();
        cyc++;
        if (!seen64 && m_f == 64) begin
          seen64 = 1;
          chk("wrap_msb", 64'(rptr[6]), 64'd1);
          chk("wrap_raddr", 64'(raddr), 64'd0);
        end
      end
      chk("wrap_count", 64'(consumed), 64'd130);
      tick();
      chk("wrap_rptr", 64'(rptr), 64'(gray(7'd2)));
    end

    // Full lap.
    do_reset(2);
    for (int i = 0; i < 64; i++) wr($urandom);
    repeat (3) tick();
    chk("lap_rempty", 64'(rempty), 64'd0);
    chk("lap_rlevel", 64'(rlevel), 64'd64);
    rready = 1'b1;
    repeat (63) tick();
    chk("lap_63_rempty", 64'(rempty), 64'd0);
    tick();
    chk("lap_64_rempty", 64'(rempty), 64'd1);
    chk("lap_64_rvalid", 64'(rvalid), 64'd1);
    tick();
    chk("lap_end_rvalid", 64'(rvalid), 64'd0);
    chk("lap_count", 64'(consumed), 64'd64);

    // Reset mid-stream.
    do_reset(2);
    for (int i = 0; i < 6; i++) wr(32'hC0DE0000 + 32'(i));
    repeat (4) tick();
    chk("mid_rvalid", 64'(rvalid), 64'd1);
    chk("mid_rlevel", 64'(rlevel), 64'd5);
    rrst_n = 1'b0;
    exp_q.delete();
    wcnt = 0;
    written = 0;
    consumed = 0;
    tick();
    chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
    chk("mid_rst_rempty", 64'(rempty), 64'd1);
    chk("mid_rst_rptr", 64'(rptr), 64'd0);
    rrst_n = 1'b1;
    rready = 1'b1;
    repeat (10) begin
      tick();
      chk("mid_stale", 64'(rvalid), 64'd0);
    end

    // Random writes and backpressure.
    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      rready = ($urandom % 4) != 0;
      if (($urandom % 3) != 0 && written - consumed < 64)
        wr($urandom);
      tick();
    end
    rready = 1'b1;
    begin
      int cyc;
      cyc = 0;
      while (consumed < written && cyc < 500) begin
        tick();
        cyc++;
      end
    end
    chk("rnd_drain", 64'(consumed), 64'(written));
    repeat (2) tick();
    chk("rnd_rempty", 64'(rempty), 64'd1);
    chk("rnd_rlevel", 64'(rlevel), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the asynchronous FIFO, and the counterpart to the write-side memory port. It runs entirely in the read clock domain. It synchronizes the write-domain Gray pointer, maintains the binary/Gray read pointer and the registered empty flag, and addresses the combinational read port of the FIFO memory. Words pass to the consumer through a registered valid/ready output stage.

## Interface
Parameters:
- DATASIZE, 32, data word width
- ADDRSIZE, 6, memory address width; depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits

Ports:
- rclk  input  1  read clock; all state updates on its rising edge
- rrst_n  input  1  synchronous reset, active-low, sampled on rclk
- wptr  input  ADDRSIZE+1  Gray-coded write pointer from the write domain (asynchronous to rclk)
- rptr  output  ADDRSIZE+1  Gray-coded read pointer, registered, to the write domain
- raddr  output  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0]
- rdata_mem  input  DATASIZE  combinational read data from memory at raddr
- rdata  output  DATASIZE  output word, registered
- rvalid  output  1  rdata holds an unconsumed word
- rready  input  1  consumer accepts rdata this cycle
- rempty  output  1  registered empty flag; no unread word left in memory
- rlevel  output  ADDRSIZE+1  words in memory not yet fetched (excludes the output register)

## Operation
- Synchronizer: two flops, rq1_wptr then rq2_wptr. Only rq2_wptr is used.
- Pointer: binary rbin, ADDRSIZE+1 bits. rptr = (rbin>>1)^rbin, registered together with rbin.
- fetch = !rempty && (!rvalid || rready).
- On fetch:
  - rdata <= rdata_mem
  - rvalid <= 1
  - rbin <= rbin+1, modulo 2^(ADDRSIZE+1)
- Consume without fetch: when rvalid && rready && !fetch, rvalid <= 0.
- Stall: when rvalid && !rready, rdata and rvalid hold and rbin does not advance.
- Empty flag:
  - rbinnext = rbin + fetch
  - rgraynext = Gray(rbinnext)
  - rempty <= (rgraynext == rq2_wptr)
- Level: rlevel = Gray2Bin(rq2_wptr) − rbin, modulo 2^(ADDRSIZE+1). It is combinational from registers and ranges 0..DEPTH.
- Wrap-around:
  - raddr wraps from DEPTH−1 to 0.
  - The pointer MSB toggles every DEPTH reads.
  - Empty is compared on the full ADDRSIZE+1 bits, so a full-lap difference is never reported as empty.
- Simultaneous consume and fetch: rvalid stays 1 and rdata takes the next word in the same edge. There is no bubble.
- An empty FIFO with rready high causes no fetch and no pointer movement. rvalid falls after the last word is consumed.
- Reset (rrst_n=0 at an edge, including mid-stream): the following are cleared in that edge and any in-flight word is discarded.
  - rbin, rptr, rq1_wptr, rq2_wptr, rdata = 0
  - rvalid = 0
  - rempty = 1
  - raddr = 0 and rlevel = 0 as a consequence
- The write domain is reset concurrently; this is a system requirement, not checked here.

## Timing
- Reset values: rptr=0, raddr=0, rdata=0, rvalid=0, rempty=1, rlevel=0.
- Empty-to-data latency: wptr stable before edge E1 → rq2_wptr updated at E2 → rempty falls at E3 → rvalid=1 with data at E4.
- rlevel reflects a new wptr after E2.
- Throughput: one word per rclk while rready=1 and rempty=0.
- rempty rises in the same edge as the fetch of the last available word.
- rptr changes only on a fetch edge, by exactly one Gray step, so the value is safe to synchronize in the write domain.
- rdata_mem is sampled in the fetch edge only. The memory read path is combinational, so raddr to rdata_mem must fit in one rclk period.

## Test plan
- Reset: hold rrst_n=0 for 3 edges with wptr=5 → rempty=1, rvalid=0, rdata=0, rptr=0, raddr=0, rlevel=0. Check again 1 edge after release with wptr=0.
- Single word: mem[0]=0xA5A50001, wptr 0→1 before E1, rready=1.
  - rempty=0 at E3
  - rvalid=1 with rdata=0xA5A50001 at E4, raddr=1, rptr=1
  - rempty=1 at E4
  - rvalid=0 at E5
- Backpressure: mem[0..2]=0x10,0x11,0x12, wptr=Gray(3)=2, rready=0 for 10 cycles.
  - rvalid=1, rdata=0x10, rptr=1 stable throughout
  - rlevel=2
  - After rready=1: 0x11 and 0x12 on consecutive edges, then rvalid=0 and rlevel=0.
- Wrap: stream 130 words with data=index and rready=1.
  - raddr 63→0 at word 64
  - rptr MSB set after 64 reads
  - rbin returns to 0 after 128 reads
  - All data in order; rempty never falsely set while rlevel>0
- Full lap: wptr=Gray(64) with rbin=0 → rempty=0, rlevel=64. Drain 64 words back-to-back; rempty rises on the 64th fetch edge.
- Reset mid-stream: assert rrst_n=0 while rvalid=1 and rlevel=5 → next edge rvalid=0, rempty=1, rptr=0. No stale word appears after release with wptr=0.
